// File: rtl/fifo_rd_ctrl_wifi_if.sv
// Read-side bundle of the WiFi PHY sample FIFO: writer pointer in, RAM read port,
// and the valid/ready sample stream toward the TX datapath.
`timescale 1ns/1ps
interface fifo_rd_ctrl_wifi_if #(
  parameter int ADDR_FIFO  = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_FIFO:0]    W_Ptr;
  logic                  Flush;
  logic [ADDR_FIFO-1:0]  R_Addr;
  logic                  R_CLK_en;
  logic [DATA_WIDTH-1:0] R_Data;
  logic [DATA_WIDTH-1:0] M_Data;
  logic                  M_Valid;
  logic                  M_Ready;
  logic                  Empty;
  logic [ADDR_FIFO:0]    Level;
  logic                  Err;

  modport master (
    input  W_Ptr, Flush, R_Data, M_Ready,
    output R_Addr, R_CLK_en, M_Data, M_Valid, Empty, Level, Err
  );

  modport slave (
    output W_Ptr, Flush, R_Data, M_Ready,
    input  R_Addr, R_CLK_en, M_Data, M_Valid, Empty, Level, Err
  );
endinterface

// File: rtl/fifo_rd_ctrl_wifi.sv
// Read controller for the WiFi PHY sample FIFO RAM: issues reads, hides the RAM's
// one-cycle latency behind a 3-word buffer. Optional pointer check: FIFO_RD_CTRL_WIFI_ERR_EN.
`timescale 1ns/1ps
module fifo_rd_ctrl_wifi #(
  parameter int ADDR_FIFO  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_FIFO = 200
) (
  input  logic                CLK,
  input  logic                RST_n,
  fifo_rd_ctrl_wifi_if.master bus
);
  localparam int                   LW        = ADDR_FIFO + 2;
  localparam logic [LW-1:0]        DEPTH_X   = LW'(DEPTH_FIFO);
  localparam logic [ADDR_FIFO-1:0] LAST_ADDR = ADDR_FIFO'(DEPTH_FIFO - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
  localparam logic [1:0] ST_THREE = 2'd3;

  logic [ADDR_FIFO:0]    r_ptr_r;
  logic [1:0]            state_r;
  logic [1:0]            state_next_s;
  logic [1:0]            wr_idx_s;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;
  logic [DATA_WIDTH-1:0] buf2_r;
  logic [LW-1:0]         w_x_s;
  logic [LW-1:0]         r_x_s;
  logic [LW-1:0]         level_x_s;
  logic [2:0]            credit_s;
  logic                  m_valid_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  issue_s;

  // Two spare bits keep an overrun (negative or >DEPTH) level distinguishable.
  assign w_x_s = {2'b00, bus.W_Ptr[ADDR_FIFO-1:0]};
  assign r_x_s = {2'b00, r_ptr_r[ADDR_FIFO-1:0]};

  // Unread RAM entries between the writer and reader pointers.
  always_comb begin
    if (bus.W_Ptr[ADDR_FIFO] == r_ptr_r[ADDR_FIFO]) begin
      level_x_s = w_x_s - r_x_s;
    end else begin
      level_x_s = DEPTH_X - r_x_s + w_x_s;
    end
  end

  assign m_valid_s = (state_r != ST_EMPTY);
  assign pop_s     = m_valid_s & bus.M_Ready;
  assign push_s    = inflight_r;
  assign wr_idx_s  = state_r - {1'b0, pop_s};
  assign credit_s  = {1'b0, state_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s   = (level_x_s != {LW{1'b0}}) & RST_n & ~bus.Flush & (credit_s < 3'd3);

  assign bus.R_Addr   = r_ptr_r[ADDR_FIFO-1:0];
  assign bus.R_CLK_en = issue_s;
  assign bus.M_Data   = buf0_r;
  assign bus.M_Valid  = m_valid_s;
  assign bus.Level    = level_x_s[ADDR_FIFO:0];
  assign bus.Empty    = (level_x_s == {LW{1'b0}}) & ~inflight_r & (state_r == ST_EMPTY);

  // Buffer occupancy state: push raises, pop lowers, both together hold.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) state_next_s = ST_ONE;
        else        state_next_s = ST_EMPTY;
      end
      ST_ONE: begin
        if (push_s & ~pop_s)      state_next_s = ST_TWO;
        else if (~push_s & pop_s) state_next_s = ST_EMPTY;
        else                      state_next_s = ST_ONE;
      end
      ST_TWO: begin
        if (push_s & ~pop_s)      state_next_s = ST_THREE;
        else if (~push_s & pop_s) state_next_s = ST_ONE;
        else                      state_next_s = ST_TWO;
      end
      ST_THREE: begin
        if (~push_s & pop_s) state_next_s = ST_TWO;
        else                 state_next_s = ST_THREE;
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Read pointer: skips from DEPTH_FIFO-1 to 0 so non-power-of-two depths wrap cleanly.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_ptr_r <= {(ADDR_FIFO+1){1'b0}};
    end else if (bus.Flush) begin
      r_ptr_r <= bus.W_Ptr;
    end else if (issue_s) begin
      if (r_ptr_r[ADDR_FIFO-1:0] == LAST_ADDR) begin
        r_ptr_r <= {~r_ptr_r[ADDR_FIFO], {ADDR_FIFO{1'b0}}};
      end else begin
        r_ptr_r <= {r_ptr_r[ADDR_FIFO], r_ptr_r[ADDR_FIFO-1:0] + ADDR_FIFO'(1)};
      end
    end
  end

  // Occupancy and in-flight tracking; clearing inflight drops a returning word on flush.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r    <= ST_EMPTY;
      inflight_r <= 1'b0;
    end else if (bus.Flush) begin
      state_r    <= ST_EMPTY;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      inflight_r <= issue_s;
    end
  end

  // Shift-style buffer: entry 0 is always the head, so M_Data is a plain register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      buf0_r <= {DATA_WIDTH{1'b0}};
      buf1_r <= {DATA_WIDTH{1'b0}};
      buf2_r <= {DATA_WIDTH{1'b0}};
    end else if (!bus.Flush) begin
      if (pop_s) begin
        buf0_r <= buf1_r;
        buf1_r <= buf2_r;
      end
      if (push_s) begin
        case (wr_idx_s)
          2'd0:    buf0_r <= bus.R_Data;
          2'd1:    buf1_r <= bus.R_Data;
          default: buf2_r <= bus.R_Data;
        endcase
      end
    end
  end

`ifdef FIFO_RD_CTRL_WIFI_ERR_EN
  logic err_r;

  // Sticky pointer error: writer address out of range or writer overran the reader.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      err_r <= 1'b0;
    end else if (bus.Flush) begin
      err_r <= 1'b0;
    end else if ((w_x_s >= DEPTH_X) || (level_x_s > DEPTH_X)) begin
      err_r <= 1'b1;
    end
  end

  assign bus.Err = err_r;
`else
  assign bus.Err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl_wifi.sv
// Bench for fifo_rd_ctrl_wifi: vector table, wrap/flush/error sequences and a
// randomized run scored against a queue model of the written sample stream.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl_wifi;
  localparam int DEPTH = 200;

`ifdef FIFO_RD_CTRL_WIFI_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct {
    int         adv;
    logic [7:0] wdata;
    logic       rdy;
    logic       en;
    logic       val;
    int         lvl;
    logic       emp;
    logic [7:0] raddr;
    logic       chk_d;
    logic [7:0] dat;
  } vec_t;

  logic CLK;
  logic RST_n;
  fifo_rd_ctrl_wifi_if #(.ADDR_FIFO(8), .DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl_wifi #(.ADDR_FIFO(8), .DATA_WIDTH(8), .DEPTH_FIFO(DEPTH)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [256];
  logic [7:0] exp_q [$];
  logic [7:0] w_addr = 8'd0;
  logic       w_wrap = 1'b0;
  int         written_cnt = 0;
  int         issued_cnt  = 0;
  int         outstanding = 0;
  int         exp_raddr   = 0;
  bit         mon_en      = 1'b1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered RAM read port
  always @(posedge CLK) begin
    if (bus.R_CLK_en) bus.R_Data <= ram[bus.R_Addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Writer: store k words into the RAM and publish the new pointer
  task automatic advance(input int k, input logic [7:0] base);
    for (int i = 0; i < k; i++) begin
      ram[w_addr] = base + 8'(i);
      exp_q.push_back(base + 8'(i));
      written_cnt++;
      if (w_addr == 8'(DEPTH - 1)) begin
        w_addr = 8'd0;
        w_wrap = ~w_wrap;
      end else begin
        w_addr = w_addr + 8'd1;
      end
    end
    bus.W_Ptr = {w_wrap, w_addr};
  endtask

  // Scoreboard: checks observed outputs against the written stream, then applies this cycle's events
  always @(negedge CLK) begin
    if (!RST_n) begin
      exp_q.delete();
      written_cnt = 0;
      issued_cnt  = 0;
      outstanding = 0;
      exp_raddr   = 0;
    end else begin
      if (mon_en) begin
        chk("level", 32'(bus.Level), 32'(written_cnt - issued_cnt));
        chk("empty", 32'(bus.Empty), 32'(exp_q.size() == 0));
        chk("err_quiet", 32'(bus.Err), 32'd0);
        if (bus.R_CLK_en) chk("r_addr", 32'(bus.R_Addr), 32'(exp_raddr));
      end
      if (bus.M_Valid && bus.M_Ready) begin
        if (mon_en) begin
          if (exp_q.size() == 0) chk("stream_extra", 32'(bus.M_Data), 32'hFFFF_FFFF);
          else                   chk("m_data", 32'(bus.M_Data), 32'(exp_q.pop_front()));
        end
        outstanding--;
      end
      if (bus.R_CLK_en) begin
        issued_cnt++;
        outstanding++;
        exp_raddr = (exp_raddr + 1) % DEPTH;
      end
      if (bus.Flush) begin
        exp_q.delete();
        written_cnt = 0;
        issued_cnt  = 0;
        outstanding = 0;
        exp_raddr   = int'(bus.W_Ptr[7:0]);
      end
      if (mon_en) chk("read_ahead_le3", 32'(outstanding <= 3), 32'd1);
    end
  end

  vec_t vecs [22];
  int   iss_cyc [$];
  int   xfr_cyc [$];
  int   iss_adr [$];
  bit   drained;

  initial begin
    //        adv wdata  rdy   en    val   lvl emp   raddr chk   dat
    vecs[0]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'd0, 1'b0, 8'h00};
    vecs[1]  = '{1, 8'hA5, 1'b1, 1'b1, 1'b0, 1, 1'b0, 8'd0, 1'b0, 8'h00};
    vecs[2]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'd1, 1'b0, 8'h00};
    vecs[3]  = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'd1, 1'b1, 8'hA5};
    vecs[4]  = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'd1, 1'b0, 8'h00};
    vecs[5]  = '{10, 8'h10, 1'b0, 1'b1, 1'b0, 10, 1'b0, 8'd1, 1'b0, 8'h00};
    vecs[6]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 9, 1'b0, 8'd2, 1'b0, 8'h00};
    vecs[7]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8, 1'b0, 8'd3, 1'b1, 8'h10};
    vecs[8]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 7, 1'b0, 8'd4, 1'b1, 8'h10};
    vecs[9]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 7, 1'b0, 8'd4, 1'b1, 8'h10};
    vecs[10] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 7, 1'b0, 8'd4, 1'b1, 8'h10};
    vecs[11] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 7, 1'b0, 8'd4, 1'b1, 8'h10};
    vecs[12] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 6, 1'b0, 8'd5, 1'b1, 8'h11};
    vecs[13] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 5, 1'b0, 8'd6, 1'b1, 8'h12};
    vecs[14] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 4, 1'b0, 8'd7, 1'b1, 8'h13};
    vecs[15] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 3, 1'b0, 8'd8, 1'b1, 8'h14};
    vecs[16] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 2, 1'b0, 8'd9, 1'b1, 8'h15};
    vecs[17] = '{0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 1'b0, 8'd10, 1'b1, 8'h16};
    vecs[18] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'd11, 1'b1, 8'h17};
    vecs[19] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'd11, 1'b1, 8'h18};
    vecs[20] = '{0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 8'd11, 1'b1, 8'h19};
    vecs[21] = '{0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'd11, 1'b0, 8'h00};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    RST_n       = 1'b0;
    bus.W_Ptr   = 9'd0;
    bus.Flush   = 1'b0;
    bus.M_Ready = 1'b0;
    bus.R_Data  = 8'h00;

    // Reset values, then reset holding off reads while the writer is ahead
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_valid", 32'(bus.M_Valid), 32'd0);
    chk("rst_en", 32'(bus.R_CLK_en), 32'd0);
    chk("rst_empty", 32'(bus.Empty), 32'd1);
    chk("rst_level", 32'(bus.Level), 32'd0);
    chk("rst_raddr", 32'(bus.R_Addr), 32'd0);
    chk("rst_mdata", 32'(bus.M_Data), 32'd0);
    chk("rst_err", 32'(bus.Err), 32'd0);
    bus.W_Ptr = 9'd3;
    @(negedge CLK);
    chk("rst_hold_en", 32'(bus.R_CLK_en), 32'd0);
    chk("rst_hold_level", 32'(bus.Level), 32'd3);
    chk("rst_hold_empty", 32'(bus.Empty), 32'd0);
    bus.W_Ptr = 9'd0;
    next_cycle();
    RST_n = 1'b1;

    // Vector table: first-word latency, then stall/credit and release
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].adv > 0) advance(vecs[i].adv, vecs[i].wdata);
      bus.M_Ready = vecs[i].rdy;
      @(negedge CLK);
      chk($sformatf("v%0d_en", i), 32'(bus.R_CLK_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_valid", i), 32'(bus.M_Valid), 32'(vecs[i].val));
      chk($sformatf("v%0d_level", i), 32'(bus.Level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_empty", i), 32'(bus.Empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d_raddr", i), 32'(bus.R_Addr), 32'(vecs[i].raddr));
      if (vecs[i].chk_d) chk($sformatf("v%0d_data", i), 32'(bus.M_Data), 32'(vecs[i].dat));
      next_cycle();
    end

    // Wrap: reader restarted at 195, writer fills 195..199 then 0..4
    mon_en    = 1'b0;
    w_addr    = 8'd195;
    w_wrap    = 1'b0;
    bus.W_Ptr = {w_wrap, w_addr};
    bus.Flush = 1'b1;
    next_cycle();
    mon_en    = 1'b1;
    bus.Flush = 1'b0;
    advance(10, 8'h60);
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (c == 0) chk("wrap_level_start", 32'(bus.Level), 32'd10);
      if (c == 5) chk("wrap_level_mid", 32'(bus.Level), 32'd5);
      if (bus.R_CLK_en) begin
        iss_cyc.push_back(c);
        iss_adr.push_back(int'(bus.R_Addr));
      end
      if (bus.M_Valid && bus.M_Ready) xfr_cyc.push_back(c);
      next_cycle();
    end
    chk("wrap_issues", 32'(iss_cyc.size()), 32'd10);
    chk("wrap_xfers", 32'(xfr_cyc.size()), 32'd10);
    if (iss_cyc.size() == 10 && xfr_cyc.size() == 10) begin
      chk("wrap_issue_gapless", 32'(iss_cyc[9] - iss_cyc[0]), 32'd9);
      chk("wrap_xfer_latency", 32'(xfr_cyc[0] - iss_cyc[0]), 32'd2);
      chk("wrap_xfer_gapless", 32'(xfr_cyc[9] - xfr_cyc[0]), 32'd9);
      for (int k = 0; k < 10; k++) chk($sformatf("wrap_addr%0d", k), 32'(iss_adr[k]), 32'((195 + k) % DEPTH));
    end
    chk("wrap_empty", 32'(bus.Empty), 32'd1);

    // Flush with two words buffered and one read returning
    bus.M_Ready = 1'b0;
    advance(6, 8'h80);
    @(negedge CLK);
    next_cycle();
    @(negedge CLK);
    next_cycle();
    @(negedge CLK);
    next_cycle();
    bus.Flush = 1'b1;
    @(negedge CLK);
    chk("flush_pre_valid", 32'(bus.M_Valid), 32'd1);
    chk("flush_pre_en", 32'(bus.R_CLK_en), 32'd0);
    next_cycle();
    bus.Flush = 1'b0;
    @(negedge CLK);
    chk("flush_valid", 32'(bus.M_Valid), 32'd0);
    chk("flush_level", 32'(bus.Level), 32'd0);
    chk("flush_empty", 32'(bus.Empty), 32'd1);
    bus.M_Ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge CLK);
      chk("flush_no_stale", 32'(bus.M_Valid), 32'd0);
    end
    next_cycle();

    // Randomized traffic with phases of eager, sluggish and always-ready consumer
    for (int c = 0; c < 3000; c++) begin
      int pct;
      int k;
      pct = ((c / 500) % 3 == 0) ? 70 : (((c / 500) % 3 == 1) ? 5 : 100);
      bus.M_Ready = ($urandom_range(0, 99) < pct);
      bus.Flush   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, 3);
        if (written_cnt - issued_cnt + k <= DEPTH) advance(k, 8'($urandom));
      end
      @(negedge CLK);
      next_cycle();
    end

    bus.Flush   = 1'b0;
    bus.M_Ready = 1'b1;
    drained     = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      @(negedge CLK);
      drained = bus.Empty;
      next_cycle();
    end
    chk("drain_empty", 32'(drained), 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);

    // Out-of-range writer address, then flush clears the error
    mon_en      = 1'b0;
    bus.M_Ready = 1'b0;
    bus.W_Ptr   = {w_wrap, 8'd210};
    next_cycle();
    @(negedge CLK);
    chk("err_set", 32'(bus.Err), 32'(ERR_ON));
    next_cycle();
    w_addr    = 8'd0;
    w_wrap    = 1'b0;
    bus.W_Ptr = 9'd0;
    bus.Flush = 1'b1;
    next_cycle();
    bus.Flush = 1'b0;
    @(negedge CLK);
    chk("err_clear", 32'(bus.Err), 32'd0);
    chk("err_flush_valid", 32'(bus.M_Valid), 32'd0);
    chk("err_flush_level", 32'(bus.Level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
